// File: rtl/seq_event_counter_if.sv
// Result handshake between the window event counter and its status consumer.
// The counter (master) publishes a window total with valid/flag/overrun.
// The consumer (slave) returns the acknowledge.
interface seq_event_counter_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ack;
  logic             over_flag;
  logic             overrun;

  modport master (
    output count_out,
    output count_valid,
    output over_flag,
    output overrun,
    input  count_ack
  );

  modport slave (
    input  count_out,
    input  count_valid,
    input  over_flag,
    input  overrun,
    output count_ack
  );
endinterface

// File: rtl/seq_event_counter.sv
// Window event counter for the "011" sequence detector match pulse.
// Counts det_in pulses over back-to-back programmable windows. Each window
// total is latched with a threshold flag behind a valid/ack handshake. A result
// that replaces an unacknowledged one sets a sticky overrun bit.
module seq_event_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  seq_event_counter_if.master res
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] acc_q;
  logic [WIN_W-1:0] cyc_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             over_q;
  logic             overrun_q;

  logic [CNT_W-1:0] acc_d;
  logic             last_d;

  // Add one pulse to the accumulator, holding at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic             inc);
    if (inc && (a != {CNT_W{1'b1}}))
      return a + CNT_ONE;
    return a;
  endfunction

  // Running total including this cycle's pulse, and last-cycle-of-window detect.
  always_comb begin
    acc_d  = sat_add(acc_q, det_in);
    last_d = (state_q == S_COUNT) && enable && (cyc_q == (win_q - WIN_ONE));
  end

  // Window FSM, accumulator and result handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cyc_q     <= '0;
      win_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      over_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && (window_len != '0)) begin
            win_q   <= window_len;
            acc_q   <= '0;
            cyc_q   <= '0;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!enable) begin
            // Abort discards the partial window; the published result is kept.
            acc_q   <= '0;
            cyc_q   <= '0;
            state_q <= S_IDLE;
          end else if (last_d) begin
            // Next window starts without a gap using the length seen now.
            acc_q <= '0;
            cyc_q <= '0;
            win_q <= window_len;
            if (window_len == '0)
              state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cyc_q <= cyc_q + WIN_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // A new result takes priority over an acknowledge in the same cycle.
      if (last_d) begin
        count_q <= acc_d;
        over_q  <= (acc_d >= threshold);
        valid_q <= 1'b1;
        if (valid_q && !res.count_ack)
          overrun_q <= 1'b1;
      end else if (valid_q && res.count_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign res.count_out   = count_q;
  assign res.count_valid = valid_q;
  assign res.over_flag   = over_q;
  assign res.overrun     = overrun_q;

endmodule

// File: tb/tb_seq_event_counter.sv
// Directed testbench for seq_event_counter with hand-computed expectations.
module tb_seq_event_counter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 8;

  logic             clk;
  logic             reset;
  logic             det_in;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] threshold;

  int n_chk;
  int n_fail;

  seq_event_counter_if #(.CNT_W(CNT_W)) bus ();

  seq_event_counter #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .det_in     (det_in),
    .enable     (enable),
    .window_len (window_len),
    .threshold  (threshold),
    .res        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int cnt, input int vld,
                            input int ovf, input int ovr);
    check_eq({tag, ".count_out"},   int'(bus.count_out),   cnt);
    check_eq({tag, ".count_valid"}, int'(bus.count_valid), vld);
    check_eq({tag, ".over_flag"},   int'(bus.over_flag),   ovf);
    check_eq({tag, ".overrun"},     int'(bus.overrun),     ovr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    det_in = 1'b0;
    bus.count_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    det_in = 1'b0;
    enable = 1'b0;
    window_len = '0;
    threshold = '0;
    bus.count_ack = 1'b0;

    // Reset and idle with det_in toggling.
    for (int i = 0; i < 2; i++) begin
      det_in = i[0];
      step();
      check_outs("reset", 0, 0, 0, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      det_in = ~det_in;
      step();
      check_outs("idle", 0, 0, 0, 0);
    end

    // Basic window: 10 cycles, pulses on cycles 1, 4, 9.
    window_len = 8'd10;
    threshold = 8'd3;
    enable = 1'b1;
    det_in = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      det_in = (k == 1 || k == 4 || k == 9);
      step();
      if (k == 8) check_eq("basic.early_valid", int'(bus.count_valid), 0);
    end
    check_outs("basic", 3, 1, 1, 0);
    enable = 1'b0;
    det_in = 1'b0;
    bus.count_ack = 1'b1;
    step();
    bus.count_ack = 1'b0;
    check_outs("basic_ack", 3, 0, 1, 0);
    step();
    check_eq("basic.ack_idle", int'(bus.count_valid), 0);

    // Saturation: 255-cycle window of pulses, then a 200-cycle window.
    do_reset();
    window_len = 8'd255;
    threshold = 8'd100;
    enable = 1'b1;
    step();
    det_in = 1'b1;
    for (int k = 0; k < 255; k++) begin
      if (k == 254) begin
        window_len = 8'd200;
        threshold = 8'd201;
      end
      step();
    end
    check_outs("sat255", 255, 1, 1, 0);
    bus.count_ack = 1'b1;
    step();
    bus.count_ack = 1'b0;
    check_eq("sat200.ack", int'(bus.count_valid), 0);
    for (int k = 1; k < 200; k++) step();
    check_outs("sat200", 200, 1, 0, 0);

    // Abort at cycle 15 of a 20-cycle window, then a fresh 4-cycle window.
    do_reset();
    window_len = 8'd20;
    threshold = 8'd1;
    enable = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      det_in = (k == 2 || k == 5);
      step();
    end
    enable = 1'b0;
    det_in = 1'b0;
    step();
    check_outs("abort", 0, 0, 0, 0);
    step();
    check_eq("abort.idle_valid", int'(bus.count_valid), 0);
    window_len = 8'd4;
    enable = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      det_in = (k == 1);
      step();
    end
    check_outs("reenable", 1, 1, 1, 0);

    // Overrun: back-to-back 4-cycle windows, never acked.
    do_reset();
    window_len = 8'd4;
    threshold = 8'd2;
    enable = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      det_in = (k < 2);
      step();
    end
    check_outs("ovr.first", 2, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      det_in = (k == 0);
      step();
    end
    check_outs("ovr.second", 1, 1, 0, 1);

    // Ack lands on the same edge as a new result.
    do_reset();
    window_len = 8'd4;
    threshold = 8'd2;
    enable = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      det_in = (k == 0);
      step();
    end
    check_outs("simul.first", 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      det_in = (k < 3);
      bus.count_ack = (k == 3);
      step();
    end
    bus.count_ack = 1'b0;
    check_outs("simul.second", 3, 1, 1, 0);
    enable = 1'b0;
    step();
    bus.count_ack = 1'b1;
    step();
    bus.count_ack = 1'b0;
    check_eq("simul.ack", int'(bus.count_valid), 0);

    // Reset at window cycle 3.
    do_reset();
    window_len = 8'd10;
    threshold = 8'd0;
    enable = 1'b1;
    step();
    det_in = 1'b1;
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    check_outs("midreset", 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) step();
    check_outs("midreset.idle", 0, 0, 0, 0);

    // window_len=1: every cycle produces a result.
    window_len = 8'd1;
    threshold = 8'd1;
    enable = 1'b1;
    det_in = 1'b0;
    step();
    det_in = 1'b1;
    step();
    check_outs("win1.a", 1, 1, 1, 0);
    det_in = 1'b0;
    step();
    check_outs("win1.b", 0, 1, 0, 1);
    det_in = 1'b1;
    step();
    check_outs("win1.c", 1, 1, 1, 1);
    threshold = 8'd0;
    det_in = 1'b0;
    step();
    check_outs("thr0", 0, 1, 1, 1);
    enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
